rx_pkt_fifo_arb: RTL

Packet-atomic round-robin arbiter in the clk_sys domain. It drains PORTS showahead 1G RX FIFOs (64-bit words with sop/eop/mod/crc_err) into one 64-bit packet stream toward the system-side RX path. A port keeps its grant from sop to eop. The block also cleans up malformed FIFO content: orphan words, missing eop and stalled fragments.

---
 rtl/rx_pkt_fifo_arb.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rx_pkt_fifo_arb.sv
// rx_pkt_fifo_arb: packet-atomic round-robin drain of PORTS showahead RX
// FIFOs into one 64-bit packet stream, cleaning malformed FIFO content.
//
// Ports:
//   clk_sys_i, rst_i        clock, synchronous active-high reset
//   pkt_avail_i/pkt_*_i     per-FIFO head word (slice i belongs to FIFO i)
//   fifo_rd_req_o           combinational pop strobe, one-hot or zero
//   pkt_*_o, pkt_val_o      registered output word, held until pkt_ready_i
//   pkt_port_o              source FIFO of the current output word
//   orphan_drop_o           one-cycle pulse per discarded orphan fragment
//
// Build option: define RX_ARB_TIMEOUT_EN to abandon ports that stall for
// TIMEOUT cycles inside a packet; without it a stalled port holds the grant.

module rx_pkt_fifo_arb #(
  parameter int PORTS   = 4,
  parameter int PORT_W  = $clog2(PORTS),
  parameter int TIMEOUT = 1024
) (
  input  logic                clk_sys_i,
  input  logic                rst_i,
  input  logic [PORTS-1:0]    pkt_avail_i,
  input  logic [PORTS*64-1:0] pkt_data_i,
  input  logic [PORTS-1:0]    pkt_sop_i,
  input  logic [PORTS-1:0]    pkt_eop_i,
  input  logic [PORTS*3-1:0]  pkt_mod_i,
  input  logic [PORTS-1:0]    pkt_crc_err_i,
  output logic [PORTS-1:0]    fifo_rd_req_o,
  output logic [63:0]         pkt_data_o,
  output logic                pkt_sop_o,
  output logic                pkt_eop_o,
  output logic [2:0]          pkt_mod_o,
  output logic                pkt_crc_err_o,
  output logic [PORT_W-1:0]   pkt_port_o,
  output logic                pkt_val_o,
  input  logic                pkt_ready_i,
  output logic                orphan_drop_o
);

  if (PORTS < 2 || PORTS > 8 || TIMEOUT < 2) begin : g_cfg_err
    $error("rx_pkt_fifo_arb: unsupported PORTS/TIMEOUT");
  end

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    FLUSH,
    TERM
  } state_t;

  state_t            state, state_n;
  logic [PORT_W-1:0] grant, grant_n;
  logic [PORT_W-1:0] rr_ptr, rr_n;
  logic [PORT_W-1:0] grant_nxt;
  logic [PORT_W-1:0] pick;
  logic              pick_vld;
  logic              in_pkt, in_pkt_n;
  logic              pop, fwd, load_term;
  logic              out_free;

  logic              h_avail;
  logic [63:0]       h_data;
  logic              h_sop;
  logic              h_eop;
  logic [2:0]        h_mod;
  logic              h_crc;

  assign out_free = !pkt_val_o || pkt_ready_i;

  assign grant_nxt = (grant == PORT_W'(PORTS - 1)) ?
                     '0 : grant + 1'b1;

  // Head word of the granted FIFO.
  always_comb begin
    h_avail = 1'b0;
    h_data  = '0;
    h_sop   = 1'b0;
    h_eop   = 1'b0;
    h_mod   = '0;
    h_crc   = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant == i[PORT_W-1:0]) begin
        h_avail = pkt_avail_i[i];
        h_data  = pkt_data_i[i*64 +: 64];
        h_sop   = pkt_sop_i[i];
        h_eop   = pkt_eop_i[i];
        h_mod   = pkt_mod_i[i*3 +: 3];
        h_crc   = pkt_crc_err_i[i];
      end
    end
  end

  // First non-empty FIFO at or after rr_ptr, wrapping at PORTS.
  always_comb begin
    logic [PORT_W:0] s;
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = 0; k < PORTS; k++) begin
      s = {1'b0, rr_ptr} + k[PORT_W:0];
      if (s >= (PORT_W+1)'(PORTS))
        s = s - (PORT_W+1)'(PORTS);
      if (!pick_vld && pkt_avail_i[s[PORT_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = s[PORT_W-1:0];
      end
    end
  end

  always_comb begin
    fifo_rd_req_o = '0;
    for (int i = 0; i < PORTS; i++)
      fifo_rd_req_o[i] = pop && (grant == i[PORT_W-1:0]);
  end

`ifdef RX_ARB_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        term_flush, term_flush_n;
  logic        stalled, tmo;

  assign stalled = (state == XFER || state == FLUSH) && !h_avail;
  assign tmo     = stalled && (idle_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      idle_cnt   <= '0;
      term_flush <= 1'b0;
    end else begin
      term_flush <= term_flush_n;
      if (pop || state == IDLE || state == TERM)
        idle_cnt <= '0;
      else if (stalled)
        idle_cnt <= idle_cnt + 16'd1;
    end
  end
`endif

  always_comb begin
    state_n       = state;
    grant_n       = grant;
    rr_n          = rr_ptr;
    in_pkt_n      = in_pkt;
    pop           = 1'b0;
    fwd           = 1'b0;
    load_term     = 1'b0;
    orphan_drop_o = 1'b0;
`ifdef RX_ARB_TIMEOUT_EN
    term_flush_n  = term_flush;
`endif
    unique case (state)
      IDLE: begin
        in_pkt_n = 1'b0;
        if (pick_vld) begin
          grant_n = pick;
          state_n = XFER;
        end
      end
      XFER: begin
`ifdef RX_ARB_TIMEOUT_EN
        if (tmo) begin
          if (in_pkt) begin
            term_flush_n = 1'b1;
            state_n      = TERM;
          end else begin
            rr_n    = grant_nxt;
            state_n = IDLE;
          end
        end else
`endif
        if (!in_pkt) begin
          if (h_avail && out_free) begin
            pop = 1'b1;
            if (h_sop) begin
              fwd      = 1'b1;
              in_pkt_n = 1'b1;
              if (h_eop) begin
                rr_n    = grant_nxt;
                state_n = IDLE;
              end
            end else if (h_eop) begin
              // Single-word orphan: dropped without moving rr_ptr.
              orphan_drop_o = 1'b1;
              state_n       = IDLE;
            end else begin
              state_n = FLUSH;
            end
          end
        end else if (h_avail) begin
          if (h_sop) begin
            // Missing eop: the new sop stays in the FIFO.
            state_n = TERM;
          end else if (out_free) begin
            pop = 1'b1;
            fwd = 1'b1;
            if (h_eop) begin
              rr_n    = grant_nxt;
              state_n = IDLE;
            end
          end
        end
      end
      TERM: begin
        if (out_free) begin
          load_term = 1'b1;
`ifdef RX_ARB_TIMEOUT_EN
          term_flush_n = 1'b0;
          if (term_flush) begin
            state_n = FLUSH;
          end else begin
            rr_n    = grant_nxt;
            state_n = IDLE;
          end
`else
          rr_n    = grant_nxt;
          state_n = IDLE;
`endif
        end
      end
      FLUSH: begin
`ifdef RX_ARB_TIMEOUT_EN
        if (tmo) begin
          rr_n    = grant_nxt;
          state_n = IDLE;
        end else
`endif
        if (h_avail) begin
          if (h_sop) begin
            orphan_drop_o = 1'b1;
            state_n       = IDLE;
          end else begin
            pop = 1'b1;
            if (h_eop) begin
              orphan_drop_o = 1'b1;
              rr_n          = grant_nxt;
              state_n       = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      in_pkt <= 1'b0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      rr_ptr <= rr_n;
      in_pkt <= in_pkt_n;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      pkt_data_o    <= '0;
      pkt_sop_o     <= 1'b0;
      pkt_eop_o     <= 1'b0;
      pkt_mod_o     <= '0;
      pkt_crc_err_o <= 1'b0;
      pkt_port_o    <= '0;
      pkt_val_o     <= 1'b0;
    end else if (fwd) begin
      pkt_data_o    <= h_data;
      pkt_sop_o     <= h_sop;
      pkt_eop_o     <= h_eop;
      pkt_mod_o     <= h_mod;
      pkt_crc_err_o <= h_crc;
      pkt_port_o    <= grant;
      pkt_val_o     <= 1'b1;
    end else if (load_term) begin
      pkt_data_o    <= '0;
      pkt_sop_o     <= 1'b0;
      pkt_eop_o     <= 1'b1;
      pkt_mod_o     <= '0;
      pkt_crc_err_o <= 1'b1;
      pkt_port_o    <= grant;
      pkt_val_o     <= 1'b1;
    end else if (out_free) begin
      pkt_val_o     <= 1'b0;
    end
  end

endmodule
